erasable_cycle_sequencer: RTL and testbench

- Sequences one erasable-core memory cycle (MCT) as 12 time slots, T01..T12.
- Arbitrates between instruction accesses and counter-increment requests (PINC/MINC).
- Decodes the address into one-hot X/Y selects and generates the read, strobe, write and reset pulses.
- Performs the destructive-readout write-back; for counter requests it applies the ones-complement increment in the same cycle.
- Sits between the sequence generator and the erasable address/strobe drivers.

---
 rtl/erasable_seq_pkg.sv | 35 +++
 rtl/erasable_seq_if.sv | 52 +++++
 rtl/erasable_addr_decode.sv | 19 +
 rtl/erasable_cycle_sequencer.sv | 116 +++++++++++
 tb/tb_erasable_cycle_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/erasable_seq_pkg.sv
// erasable_seq_pkg: shared slot/owner types, constants and slot windows; ERASABLE_PARITY_EN adds a parity bit
package erasable_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12
    } slot_t;

    typedef enum logic [1:0] {NONE, INS, CTR} owner_t;

    localparam logic [14:0] MINUS_ONE = 15'h7FFE;

`ifdef ERASABLE_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    localparam slot_t SEL_LO  = T02;
    localparam slot_t SEL_HI  = T11;
    localparam slot_t RD_LO   = T03;
    localparam slot_t RD_HI   = T04;
    localparam slot_t SBE_T   = T05;
    localparam slot_t IDONE_T = T06;
    localparam slot_t INC_T   = T07;
    localparam slot_t IWR_T   = T09;
    localparam slot_t WR_LO   = T10;
    localparam slot_t WR_HI   = T11;
    localparam slot_t CDONE_T = T11;
    localparam slot_t RST_T   = T12;

    function automatic logic in_win(input slot_t s, input slot_t lo, input slot_t hi);
        return s >= lo && s <= hi;
    endfunction

endpackage

// File: rtl/erasable_seq_if.sv
// erasable_seq_if: request, sense and core-drive bundle of the erasable cycle sequencer; parity_err exists only under ERASABLE_PARITY_EN
interface erasable_seq_if #(
    parameter int AW = 8,
    parameter int DW = 15
);
    localparam int SW = DW + erasable_seq_pkg::PAR_W;

    logic          adv;
    logic          ins_req;
    logic [AW-1:0] ins_addr;
    logic [DW-1:0] ins_wdata;
    logic          ins_wsel;
    logic          ctr_req;
    logic [AW-1:0] ctr_addr;
    logic          ctr_dir;
    logic [SW-1:0] sense;
    logic [7:0]    xb;
    logic [7:0]    xt;
    logic [3:0]    yb;
    logic          rex;
    logic          rey;
    logic          wex;
    logic          wey;
    logic          sbe;
    logic          reset_sel;
    logic [SW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ins_done;
    logic          ctr_done;
    logic          ovf;
    logic          busy;
`ifdef ERASABLE_PARITY_EN
    logic          parity_err;
`endif

    modport slave (
        input  adv, ins_req, ins_addr, ins_wdata, ins_wsel, ctr_req, ctr_addr, ctr_dir, sense,
        output xb, xt, yb, rex, rey, wex, wey, sbe, reset_sel, wdata, rdata, ins_done, ctr_done, ovf, busy
`ifdef ERASABLE_PARITY_EN
        , output parity_err
`endif
    );

    modport master (
        output adv, ins_req, ins_addr, ins_wdata, ins_wsel, ctr_req, ctr_addr, ctr_dir, sense,
        input  xb, xt, yb, rex, rey, wex, wey, sbe, reset_sel, wdata, rdata, ins_done, ctr_done, ovf, busy
`ifdef ERASABLE_PARITY_EN
        , input parity_err
`endif
    );

endinterface

// File: rtl/erasable_addr_decode.sv
// erasable_addr_decode: one-hot X/Y select decode of an erasable word address, gated by en
module erasable_addr_decode #(
    parameter int AW = 8
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [7:0]    xb,
    output logic [7:0]    xt,
    output logic [3:0]    yb
);

    // xb = addr[2:0], xt = addr[5:3], yb = addr[7:6]; all low outside the select window
    always_comb begin
        xb = en ? 8'd1 << addr[2:0] : 8'd0;
        xt = en ? 8'd1 << addr[5:3] : 8'd0;
        yb = en ? 4'd1 << addr[7:6] : 4'd0;
    end

endmodule

// File: rtl/erasable_cycle_sequencer.sv
// erasable_cycle_sequencer: 12-slot erasable memory cycle with PINC/MINC arbitration and write-back; ERASABLE_PARITY_EN enables odd parity
module erasable_cycle_sequencer
    import erasable_seq_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 15
) (
    input  logic          clk,
    input  logic          rst,
    erasable_seq_if.slave bus
);

    localparam int SW = DW + PAR_W;

    slot_t         slot, slot_nx;
    owner_t        owner, owner_nx;
    logic [AW-1:0] addr_q;
    logic          dir_q;
    logic [DW-1:0] rdata_q;
    logic [SW-1:0] wdata_q;
    logic [DW:0]   sum;
    logic [DW-1:0] inc_w;
    logic          any_req;
    logic          ovf_w;

    function automatic logic [SW-1:0] with_par(input logic [DW-1:0] w);
`ifdef ERASABLE_PARITY_EN
        return {~^w, w};
`else
        return w;
`endif
    endfunction

    assign any_req = bus.ins_req | bus.ctr_req;
    assign sum     = {1'b0, rdata_q} + {1'b0, dir_q ? DW'(MINUS_ONE) : DW'(1)};
    assign inc_w   = sum[DW-1:0] + DW'(sum[DW]);
    assign ovf_w   = rdata_q == {dir_q, {(DW-1){~dir_q}}};

    // slot and owner registers; adv=0 freezes the whole cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot  <= IDLE;
            owner <= NONE;
        end else if (bus.adv) begin
            slot  <= slot_nx;
            owner <= owner_nx;
        end
    end

    // slot sequencing; a T01 with no request left falls back to IDLE, counters win arbitration
    always_comb begin
        slot_nx  = (slot == IDLE || slot == T12) ? (any_req ? T01 : IDLE) :
                   (slot == T01) ? (any_req ? T02 : IDLE) : slot_t'(slot + 4'd1);
        owner_nx = (slot == T01) ? (bus.ctr_req ? CTR : bus.ins_req ? INS : NONE) :
                   (slot == T12) ? NONE : owner;
    end

    // address capture, sense capture and write-back word; wdata returns to zero after T12
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            dir_q   <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
        end else if (bus.adv) begin
            if (slot == T01) begin
                addr_q <= bus.ctr_req ? bus.ctr_addr : bus.ins_addr;
                dir_q  <= bus.ctr_dir;
            end
            if (slot == SBE_T)
                rdata_q <= bus.sense[DW-1:0];
            if (slot == INC_T && owner == CTR)
                wdata_q <= with_par(inc_w);
            if (slot == IWR_T && owner == INS)
                wdata_q <= with_par(bus.ins_wsel ? bus.ins_wdata : rdata_q);
            if (slot == RST_T)
                wdata_q <= '0;
        end
    end

`ifdef ERASABLE_PARITY_EN
    logic perr_q;

    // odd parity over the full sense word is checked as it is strobed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perr_q <= 1'b0;
        else if (bus.adv && slot == SBE_T)
            perr_q <= ~^bus.sense;
    end

    assign bus.parity_err = slot == IDONE_T && perr_q;
`endif

    erasable_addr_decode #(.AW(AW)) u_dec (
        .en   (in_win(slot, SEL_LO, SEL_HI)),
        .addr (addr_q),
        .xb   (bus.xb),
        .xt   (bus.xt),
        .yb   (bus.yb)
    );

    assign bus.busy      = slot != IDLE;
    assign bus.rex       = in_win(slot, RD_LO, RD_HI);
    assign bus.rey       = in_win(slot, RD_LO, RD_HI);
    assign bus.sbe       = slot == SBE_T;
    assign bus.wex       = in_win(slot, WR_LO, WR_HI);
    assign bus.wey       = in_win(slot, WR_LO, WR_HI);
    assign bus.reset_sel = slot == RST_T;
    assign bus.ins_done  = slot == IDONE_T && owner == INS;
    assign bus.ctr_done  = slot == CDONE_T && owner == CTR;
    assign bus.ovf       = slot == INC_T && owner == CTR && ovf_w;
    assign bus.rdata     = rdata_q;
    assign bus.wdata     = wdata_q;

endmodule

// File: tb/tb_erasable_cycle_sequencer.sv
// tb_erasable_cycle_sequencer: directed and randomized cycles checked slot by slot against a ones-complement reference model
module tb_erasable_cycle_sequencer;
    import erasable_seq_pkg::*;

    localparam int DW = 15;
    localparam int SW = DW + PAR_W;

    logic          clk = 1'b0;
    logic          rst;
    int            nvec = 0;
    int            nerr = 0;
    logic [DW-1:0] prev_rdata;

    erasable_seq_if bus ();

    erasable_cycle_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ones-complement add of +1 or -1 (0x7FFE) with end-around carry, in plain integer arithmetic
    function automatic logic [DW-1:0] oc_add(input logic [DW-1:0] v, input bit minus);
        int s;
        s = int'(v) + (minus ? 'h7FFE : 1);
        if (s > 'h7FFF) s = s - 'h7FFF;
        return DW'(s);
    endfunction

    // overflow: operands of equal sign giving a result of the other sign
    function automatic bit oc_ovf(input logic [DW-1:0] v, input bit minus);
        logic [DW-1:0] r;
        r = oc_add(v, minus);
        return (v[DW-1] == minus) && (r[DW-1] != v[DW-1]);
    endfunction

    function automatic logic [SW-1:0] mkw(input logic [DW-1:0] w, input bit bad);
        logic [DW:0] t;
        t = {(($countones(w) % 2) == 0) ^ bad, w};
        return SW'(t);
    endfunction

    function automatic logic [30:0] obs_ctrl();
        logic pe;
`ifdef ERASABLE_PARITY_EN
        pe = bus.parity_err;
`else
        pe = 1'b0;
`endif
        return {bus.busy, bus.xb, bus.xt, bus.yb, bus.rex, bus.rey, bus.sbe, bus.wex, bus.wey,
                bus.reset_sel, bus.ins_done, bus.ctr_done, bus.ovf, pe};
    endfunction

    function automatic logic [30:0] exp_ctrl(input int s, input bit ctr, input int addr, input bit ov, input bit pe);
        bit sel;
        sel = s >= 2 && s <= 11;
        return {s != 0,
                sel ? 8'(1 << (addr % 8)) : 8'h00,
                sel ? 8'(1 << ((addr / 8) % 8)) : 8'h00,
                sel ? 4'(1 << (addr / 64)) : 4'h0,
                s == 3 || s == 4, s == 3 || s == 4, s == 5,
                s == 10 || s == 11, s == 10 || s == 11, s == 12,
                !ctr && s == 6, ctr && s == 11, ctr && ov && s == 7, pe && s == 6};
    endfunction

    task automatic chk(input string tag, input int s, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s slot %0d: observed %h expected %h", tag, s, obs, exp);
        end
    endtask

    task automatic cmp(input int s, input bit ctr, input int addr, input bit ov, input bit pe,
                       input logic [DW-1:0] re, input logic [SW-1:0] we);
        chk("ctrl", s, 64'(obs_ctrl()), 64'(exp_ctrl(s, ctr, addr, ov, pe)));
        chk("rdata", s, 64'(bus.rdata), 64'(re));
        chk("wdata", s, 64'(bus.wdata), 64'(we));
    endtask

    task automatic idle_chk();
        @(posedge clk);
        #1;
        cmp(0, 1'b0, 0, 1'b0, 1'b0, prev_rdata, SW'(0));
    endtask

    // one full cycle from the edge that enters T01; stall_at/abort_at select a slot (0 = none)
    task automatic do_cycle(input bit ctr, input int addr, input bit minus, input logic [DW-1:0] sv,
                            input bit bad, input bit wsel, input logic [DW-1:0] wd,
                            input int stall_at, input int abort_at);
        logic [DW-1:0] res;
        logic [DW-1:0] er;
        logic [SW-1:0] ew;
        bit            ov;
        res = ctr ? oc_add(sv, minus) : (wsel ? wd : sv);
        ov  = ctr && oc_ovf(sv, minus);
        bus.sense = mkw(sv, bad);
        if (ctr) begin
            bus.ctr_addr = 8'(addr);
            bus.ctr_dir  = minus;
            bus.ctr_req  = 1'b1;
        end else begin
            bus.ins_addr  = 8'(addr);
            bus.ins_wsel  = wsel;
            bus.ins_wdata = wd;
            bus.ins_req   = 1'b1;
        end
        for (int s = 1; s <= 12; s++) begin
            @(posedge clk);
            #1;
            er = s >= 6 ? sv : prev_rdata;
            ew = s >= (ctr ? 8 : 10) ? mkw(res, 1'b0) : SW'(0);
            cmp(s, ctr, addr, ov, bad, er, ew);
            if (s == stall_at) begin
                bus.adv = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    cmp(s, ctr, addr, ov, bad, er, ew);
                end
                bus.adv = 1'b1;
            end
            if (s == abort_at) begin
                rst = 1'b1;
                bus.ins_req = 1'b0;
                bus.ctr_req = 1'b0;
                #1;
                prev_rdata = '0;
                cmp(0, 1'b0, 0, 1'b0, 1'b0, prev_rdata, SW'(0));
                @(posedge clk);
                #1;
                rst = 1'b0;
                cmp(0, 1'b0, 0, 1'b0, 1'b0, prev_rdata, SW'(0));
                idle_chk();
                return;
            end
            if (!ctr && s == 6) bus.ins_req = 1'b0;
            if (ctr && s == 11) bus.ctr_req = 1'b0;
        end
        prev_rdata = sv;
    endtask

    initial begin
        logic [DW-1:0] sv;
        logic [DW-1:0] wd;
        logic [DW-1:0] corner [5];
        bit            ctr;
        bit            bad;
        int            stall;
        corner[0] = 15'h3FFF;
        corner[1] = 15'h4000;
        corner[2] = 15'h7FFF;
        corner[3] = 15'h0000;
        corner[4] = 15'h0001;
        rst           = 1'b1;
        bus.adv       = 1'b1;
        bus.ins_req   = 1'b0;
        bus.ins_addr  = '0;
        bus.ins_wdata = '0;
        bus.ins_wsel  = 1'b0;
        bus.ctr_req   = 1'b0;
        bus.ctr_addr  = '0;
        bus.ctr_dir   = 1'b0;
        bus.sense     = '0;
        prev_rdata    = '0;
        repeat (2) @(posedge clk);
        #1;
        cmp(0, 1'b0, 0, 1'b0, 1'b0, prev_rdata, SW'(0));
        rst = 1'b0;
        idle_chk();

        do_cycle(1'b0, 'hA5, 1'b0, 15'h1234, 1'b0, 1'b0, 15'h0000, 0, 0);
        idle_chk();
        do_cycle(1'b1, 'h3C, 1'b0, 15'h3FFF, 1'b0, 1'b0, 15'h0000, 0, 0);
        idle_chk();
        do_cycle(1'b1, 'h17, 1'b1, 15'h0000, 1'b0, 1'b0, 15'h0000, 0, 0);
        idle_chk();
        do_cycle(1'b1, 'h42, 1'b1, 15'h4000, 1'b0, 1'b0, 15'h0000, 0, 0);
        idle_chk();
        do_cycle(1'b1, 'h81, 1'b0, 15'h7FFF, 1'b0, 1'b0, 15'h0000, 0, 0);
        idle_chk();

        bus.ins_req  = 1'b1;
        bus.ins_addr = 8'h5A;
        do_cycle(1'b1, 'hC3, 1'b1, 15'h0001, 1'b0, 1'b0, 15'h0000, 0, 0);
        do_cycle(1'b0, 'h5A, 1'b0, 15'h2222, 1'b0, 1'b1, 15'h6D6D, 0, 0);
        idle_chk();

        do_cycle(1'b0, 'hFF, 1'b0, 15'h0F0F, 1'b0, 1'b1, 15'h5555, 3, 0);
        idle_chk();
        do_cycle(1'b0, 'h66, 1'b0, 15'h3333, 1'b0, 1'b0, 15'h0000, 0, 10);

`ifdef ERASABLE_PARITY_EN
        do_cycle(1'b1, 'h09, 1'b0, 15'h0123, 1'b1, 1'b0, 15'h0000, 0, 0);
        idle_chk();
        do_cycle(1'b0, 'h90, 1'b0, 15'h7654, 1'b1, 1'b1, 15'h0ACE, 0, 0);
        idle_chk();
`endif

        for (int i = 0; i < 24; i++) begin
            ctr   = 1'(($urandom % 2));
            sv    = ($urandom % 3 == 0) ? corner[$urandom_range(0, 4)] : DW'($urandom);
            wd    = DW'($urandom);
            bad   = (PAR_W != 0) && ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            do_cycle(ctr, int'($urandom_range(0, 255)), 1'(($urandom % 2)), sv, bad,
                     1'(($urandom % 2)), wd, stall, 0);
            idle_chk();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
